// File: rtl/uart_pkg.sv
// uart_pkg: shared 8N1 framing constants and FSM state encodings for uart_ctrl.
package uart_pkg;

  localparam int   DATA_BITS   = 8;
  localparam int   BIT_IDX_W   = $clog2(DATA_BITS);
  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;
  localparam logic IDLE_LEVEL  = 1'b1;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_RECOVER
  } rx_state_e;

endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: small synchronous receive FIFO. DEPTH must be a power of two
// (>= 2). Pointers carry one extra wrap bit so full and empty are distinct.
// head_data reads as zero while empty so the consumer never sees stale data.
module uart_rx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty,
  output logic             overrun
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees a slot, so a push into a full FIFO is legal then.
  assign do_push = push && (!full || do_pop);

  assign head_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

  // Storage array write.
  // NOTE: the data array has no reset; validity is tracked by the pointers alone,
  // which keeps it a plain RAM-style structure.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  // Pointer and overrun pulse registers.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      overrun <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      overrun <= push && !do_push;
    end
  end

endmodule

// File: rtl/uart_ctrl.sv
// uart_ctrl: device-side 8N1 UART, LSB first. Transmit path has a
// start/busy/done handshake; receive path has a 2-flop synchronizer, a
// mid-bit sampling FSM with glitch rejection and frame-error recovery, and a
// valid/ready output stage. Define UART_RX_FIFO_EN to replace the single
// holding register with a RX_FIFO_DEPTH-entry FIFO (uart_rx_fifo).
module uart_ctrl
  import uart_pkg::*;
#(
  parameter int CLK_FREQ      = 40000000,
  parameter int BAUD          = 9600,
  parameter int RX_FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ser_rx,
  output logic                 ser_tx,
  input  logic                 tx_start,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_busy,
  output logic                 tx_done,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_frame_err,
  output logic                 rx_overrun
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);

  localparam logic [CNT_W-1:0]     BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  // The FSM spends one cycle registering the start edge, so the start-bit
  // check one count early lands on the true mid-bit point.
  localparam logic [CNT_W-1:0]     HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BIT_IDX_W-1:0] LAST_BIT  = BIT_IDX_W'(DATA_BITS - 1);

  // ---------------------------------------------------------------------------
  // Transmitter
  // ---------------------------------------------------------------------------
  tx_state_e              tx_state, tx_state_nxt;
  logic [CNT_W-1:0]       tx_cnt, tx_cnt_nxt;
  logic [BIT_IDX_W-1:0]   tx_bit, tx_bit_nxt;
  logic [DATA_BITS-1:0]   tx_shift, tx_shift_nxt;
  logic                   ser_tx_nxt;

  // TX state, counters and the registered line driver.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      ser_tx   <= IDLE_LEVEL;
    end else begin
      tx_state <= tx_state_nxt;
      tx_cnt   <= tx_cnt_nxt;
      tx_bit   <= tx_bit_nxt;
      tx_shift <= tx_shift_nxt;
      ser_tx   <= ser_tx_nxt;
    end
  end

  // TX next-state: each bit lasts CLKS_PER_BIT cycles; tx_start only sampled in IDLE.
  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    tx_state_nxt = tx_state;
    tx_cnt_nxt   = tx_cnt;
    tx_bit_nxt   = tx_bit;
    tx_shift_nxt = tx_shift;
    tx_done      = 1'b0;
    case (tx_state)
      TX_IDLE: begin
        if (tx_start) begin
          tx_shift_nxt = tx_data;
          tx_cnt_nxt   = '0;
          tx_bit_nxt   = '0;
          tx_state_nxt = TX_START;
        end
      end
      TX_START: begin
        if (tx_cnt == BIT_LAST) begin
          tx_cnt_nxt   = '0;
          tx_state_nxt = TX_DATA;
        end else begin
          tx_cnt_nxt = tx_cnt + 1'b1;
        end
      end
      TX_DATA: begin
        if (tx_cnt == BIT_LAST) begin
          tx_cnt_nxt   = '0;
          tx_shift_nxt = tx_shift >> 1;
          if (tx_bit == LAST_BIT) tx_state_nxt = TX_STOP;
          else                    tx_bit_nxt   = tx_bit + 1'b1;
        end else begin
          tx_cnt_nxt = tx_cnt + 1'b1;
        end
      end
      TX_STOP: begin
        if (tx_cnt == BIT_LAST) begin
          tx_cnt_nxt   = '0;
          tx_done      = 1'b1;
          tx_state_nxt = TX_IDLE;
        end else begin
          tx_cnt_nxt = tx_cnt + 1'b1;
        end
      end
      default: tx_state_nxt = TX_IDLE;
    endcase
  end

  // Line level for the coming cycle, derived from the next state so ser_tx is a clean flop.
  always_comb begin
    ser_tx_nxt = IDLE_LEVEL;
    case (tx_state_nxt)
      TX_START: ser_tx_nxt = START_LEVEL;
      TX_DATA:  ser_tx_nxt = tx_shift_nxt[0];
      TX_STOP:  ser_tx_nxt = STOP_LEVEL;
      default:  ser_tx_nxt = IDLE_LEVEL;
    endcase
  end

  assign tx_busy = (tx_state != TX_IDLE);

  // ---------------------------------------------------------------------------
  // Receiver
  // ---------------------------------------------------------------------------
  logic [1:0]             rx_sync;
  logic                   rx_s;
  rx_state_e              rx_state, rx_state_nxt;
  logic [CNT_W-1:0]       rx_cnt, rx_cnt_nxt;
  logic [BIT_IDX_W-1:0]   rx_bit, rx_bit_nxt;
  logic [DATA_BITS-1:0]   rx_shift, rx_shift_nxt;
  logic                   rx_push;
  logic                   rx_ferr_set;
  logic                   rx_pop;

  // Two-flop synchronizer; resets to the idle line level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rx_sync <= 2'b11;
    else        rx_sync <= {rx_sync[0], ser_rx};
  end

  assign rx_s = rx_sync[1];

  // RX state, counters, shift register and the frame-error pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state     <= RX_IDLE;
      rx_cnt       <= '0;
      rx_bit       <= '0;
      rx_shift     <= '0;
      rx_frame_err <= 1'b0;
    end else begin
      rx_state     <= rx_state_nxt;
      rx_cnt       <= rx_cnt_nxt;
      rx_bit       <= rx_bit_nxt;
      rx_shift     <= rx_shift_nxt;
      rx_frame_err <= rx_ferr_set;
    end
  end

  // RX next-state: confirm start at mid-bit, then sample once per bit period.
  always_comb begin
    rx_state_nxt = rx_state;
    rx_cnt_nxt   = rx_cnt;
    rx_bit_nxt   = rx_bit;
    rx_shift_nxt = rx_shift;
    rx_push      = 1'b0;
    rx_ferr_set  = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        if (rx_s == START_LEVEL) begin
          rx_cnt_nxt   = '0;
          rx_state_nxt = RX_START;
        end
      end
      RX_START: begin
        if (rx_cnt == HALF_LAST) begin
          rx_cnt_nxt = '0;
          rx_bit_nxt = '0;
          // A start bit that is no longer low at mid-bit was a glitch.
          rx_state_nxt = (rx_s == START_LEVEL) ? RX_DATA : RX_IDLE;
        end else begin
          rx_cnt_nxt = rx_cnt + 1'b1;
        end
      end
      RX_DATA: begin
        if (rx_cnt == BIT_LAST) begin
          rx_cnt_nxt   = '0;
          rx_shift_nxt = {rx_s, rx_shift[DATA_BITS-1:1]};
          if (rx_bit == LAST_BIT) rx_state_nxt = RX_STOP;
          else                    rx_bit_nxt   = rx_bit + 1'b1;
        end else begin
          rx_cnt_nxt = rx_cnt + 1'b1;
        end
      end
      RX_STOP: begin
        if (rx_cnt == BIT_LAST) begin
          rx_cnt_nxt = '0;
          if (rx_s == STOP_LEVEL) begin
            rx_push      = 1'b1;
            rx_state_nxt = RX_IDLE;
          end else begin
            rx_ferr_set  = 1'b1;
            rx_state_nxt = RX_RECOVER;
          end
        end else begin
          rx_cnt_nxt = rx_cnt + 1'b1;
        end
      end
      RX_RECOVER: begin
        // Hold off until the line returns high so a stuck-low line is not re-framed.
        if (rx_s == IDLE_LEVEL) rx_state_nxt = RX_IDLE;
      end
      default: rx_state_nxt = RX_IDLE;
    endcase
  end

  assign rx_pop = rx_valid && rx_ready;

  // ---------------------------------------------------------------------------
  // Receive storage
  // ---------------------------------------------------------------------------
`ifdef UART_RX_FIFO_EN
  logic fifo_empty;
  logic fifo_full;

  uart_rx_fifo #(
    .DEPTH (RX_FIFO_DEPTH),
    .WIDTH (DATA_BITS)
  ) u_rx_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (rx_push),
    .push_data (rx_shift),
    .pop       (rx_pop),
    .head_data (rx_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .overrun   (rx_overrun)
  );

  assign rx_valid = !fifo_empty;
`else
  // Single holding register: a simultaneous pop makes room for the new byte;
  // otherwise a push onto a held byte is dropped and flagged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      rx_overrun <= 1'b0;
    end else begin
      rx_overrun <= 1'b0;
      if (rx_push) begin
        if (!rx_valid || rx_pop) begin
          rx_data  <= rx_shift;
          rx_valid <= 1'b1;
        end else begin
          rx_overrun <= 1'b1;
        end
      end else if (rx_pop) begin
        rx_valid <= 1'b0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_uart_ctrl.sv
// tb_uart_ctrl: directed self-checking bench for uart_ctrl at 16 clocks per bit.
module tb_uart_ctrl;

  localparam int CPB = 16;

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b0;
  logic       ser_rx   = 1'b1;
  logic       tx_start = 1'b0;
  logic [7:0] tx_data  = 8'h00;
  logic       rx_ready = 1'b0;
  logic       ser_tx;
  logic       tx_busy;
  logic       tx_done;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_frame_err;
  logic       rx_overrun;

  uart_ctrl #(
    .CLK_FREQ      (16),
    .BAUD          (1),
    .RX_FIFO_DEPTH (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ser_rx       (ser_rx),
    .ser_tx       (ser_tx),
    .tx_start     (tx_start),
    .tx_data      (tx_data),
    .tx_busy      (tx_busy),
    .tx_done      (tx_done),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .rx_frame_err (rx_frame_err),
    .rx_overrun   (rx_overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Free-running cycle count (changes on posedge) and event counters sampled on negedge.
  int   cyc       = 0;
  int   fe_cnt    = 0;
  int   ov_cnt    = 0;
  int   done_cnt  = 0;
  int   rise_cnt  = 0;
  int   last_rise = 0;
  logic prev_valid = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_frame_err) fe_cnt++;
    if (rx_overrun)   ov_cnt++;
    if (tx_done)      done_cnt++;
    if (rx_valid && !prev_valid) begin
      rise_cnt++;
      last_rise = cyc;
    end
    prev_valid = rx_valid;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drive one 8N1 frame into ser_rx, one bit every CPB cycles.
  task automatic send_rx(input logic [7:0] d, input logic stop_bit, output int start_cyc);
    logic [9:0] frame;
    frame = {stop_bit, d, 1'b0};
    @(negedge clk);
    start_cyc = cyc;
    for (int i = 0; i < 10; i++) begin
      ser_rx = frame[i];
      repeat (CPB) @(negedge clk);
    end
    ser_rx = 1'b1;
  endtask

  task automatic pop_one();
    @(negedge clk);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  // Start a frame and check ser_tx/tx_busy/tx_done on every cycle through the first idle cycle.
  task automatic tx_frame(input logic [7:0] d);
    logic [9:0] frame;
    logic       exp_tx;
    int         d0;
    frame = {1'b1, d, 1'b0};
    d0 = done_cnt;
    @(negedge clk);
    tx_start = 1'b1;
    tx_data  = d;
    @(posedge clk);
    #1;
    tx_start = 1'b0;
    for (int c = 1; c <= 161; c++) begin
      exp_tx = (c <= 160) ? frame[(c - 1) / CPB] : 1'b1;
      checks++;
      if (ser_tx !== exp_tx) begin
        errors++;
        $display("FAIL tx_line byte %h cycle %0d: ser_tx=%b expected %b", d, c, ser_tx, exp_tx);
      end
      checks++;
      if (tx_busy !== (c <= 160)) begin
        errors++;
        $display("FAIL tx_busy byte %h cycle %0d: got %b expected %b", d, c, tx_busy, (c <= 160));
      end
      checks++;
      if (tx_done !== (c == 160)) begin
        errors++;
        $display("FAIL tx_done byte %h cycle %0d: got %b expected %b", d, c, tx_done, (c == 160));
      end
      if (c < 161) begin
        @(posedge clk);
        #1;
      end
    end
    @(negedge clk);
    checks++;
    if (done_cnt - d0 !== 1) begin
      errors++;
      $display("FAIL tx_done_count byte %h: got %0d expected 1", d, done_cnt - d0);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (ser_tx !== 1'b1)     begin errors++; $display("FAIL reset_ser_tx: got %b expected 1", ser_tx); end
    checks++; if (tx_busy !== 1'b0)    begin errors++; $display("FAIL reset_tx_busy: got %b expected 0", tx_busy); end
    checks++; if (tx_done !== 1'b0)    begin errors++; $display("FAIL reset_tx_done: got %b expected 0", tx_done); end
    checks++; if (rx_data !== 8'h00)   begin errors++; $display("FAIL reset_rx_data: got %h expected 00", rx_data); end
    checks++; if (rx_valid !== 1'b0)   begin errors++; $display("FAIL reset_rx_valid: got %b expected 0", rx_valid); end
    checks++; if (rx_frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b expected 0", rx_frame_err); end
    checks++; if (rx_overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b expected 0", rx_overrun); end
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    checks++; if (ser_tx !== 1'b1 || tx_busy !== 1'b0 || rx_valid !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle: ser_tx=%b tx_busy=%b rx_valid=%b expected 1 0 0", ser_tx, tx_busy, rx_valid);
    end
  endtask

  task automatic test_tx();
    tx_frame(8'hA5);
  endtask

  task automatic test_back_to_back();
    int d0;
    d0 = done_cnt;
    @(negedge clk);
    tx_start = 1'b1;
    tx_data  = 8'h81;
    @(posedge clk);
    #1;
    for (int c = 1; c <= 322; c++) begin
      if (c == 160) begin
        checks++; if (tx_done !== 1'b1) begin errors++; $display("FAIL b2b_done1: got %b expected 1", tx_done); end
      end
      if (c == 161) begin
        checks++; if (ser_tx !== 1'b1 || tx_busy !== 1'b0) begin
          errors++; $display("FAIL b2b_gap: ser_tx=%b tx_busy=%b expected 1 0", ser_tx, tx_busy);
        end
      end
      if (c == 162) begin
        checks++; if (ser_tx !== 1'b0 || tx_busy !== 1'b1) begin
          errors++; $display("FAIL b2b_restart: ser_tx=%b tx_busy=%b expected 0 1", ser_tx, tx_busy);
        end
        tx_start = 1'b0;
      end
      if (c == 178) begin
        checks++; if (ser_tx !== 1'b1) begin errors++; $display("FAIL b2b_bit0: got %b expected 1", ser_tx); end
      end
      if (c == 194) begin
        checks++; if (ser_tx !== 1'b0) begin errors++; $display("FAIL b2b_bit1: got %b expected 0", ser_tx); end
      end
      if (c == 321) begin
        checks++; if (tx_done !== 1'b1) begin errors++; $display("FAIL b2b_done2: got %b expected 1", tx_done); end
      end
      if (c == 322) begin
        checks++; if (tx_busy !== 1'b0 || ser_tx !== 1'b1) begin
          errors++; $display("FAIL b2b_end_idle: tx_busy=%b ser_tx=%b expected 0 1", tx_busy, ser_tx);
        end
      end
      if (c < 322) begin
        @(posedge clk);
        #1;
      end
    end
    @(negedge clk);
    checks++;
    if (done_cnt - d0 !== 2) begin
      errors++; $display("FAIL b2b_done_count: got %0d expected 2", done_cnt - d0);
    end
  endtask

  task automatic test_rx_basic();
    int s, r0, f0, o0, lat;
    r0 = rise_cnt; f0 = fe_cnt; o0 = ov_cnt;
    send_rx(8'h3C, 1'b1, s);
    repeat (4) @(negedge clk);
    lat = last_rise - s;
    checks++; if (rise_cnt - r0 !== 1) begin errors++; $display("FAIL rx_valid_rises: got %0d expected 1", rise_cnt - r0); end
    checks++; if (lat < 154 || lat > 156) begin errors++; $display("FAIL rx_latency: got %0d expected 155 (+/-1)", lat); end
    checks++; if (rx_data !== 8'h3C) begin errors++; $display("FAIL rx_data_3c: got %h expected 3c", rx_data); end
    checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL rx_valid_hold: got %b expected 1", rx_valid); end
    checks++; if (fe_cnt != f0 || ov_cnt != o0) begin
      errors++; $display("FAIL rx_no_errors: frame_err=%0d overrun=%0d expected 0 0", fe_cnt - f0, ov_cnt - o0);
    end
    pop_one();
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL rx_pop: rx_valid=%b expected 0", rx_valid); end
  endtask

  task automatic test_frame_err();
    int s, r0, f0, o0;
    r0 = rise_cnt; f0 = fe_cnt; o0 = ov_cnt;
    send_rx(8'hA3, 1'b0, s);
    repeat (20) @(negedge clk);
    checks++; if (fe_cnt - f0 !== 1) begin errors++; $display("FAIL ferr_pulse: got %0d expected 1", fe_cnt - f0); end
    checks++; if (rise_cnt != r0 || rx_valid !== 1'b0) begin
      errors++; $display("FAIL ferr_no_valid: rises=%0d rx_valid=%b expected 0 0", rise_cnt - r0, rx_valid);
    end
    send_rx(8'h55, 1'b1, s);
    repeat (4) @(negedge clk);
    checks++; if (rx_data !== 8'h55 || rx_valid !== 1'b1) begin
      errors++; $display("FAIL ferr_recover: rx_data=%h rx_valid=%b expected 55 1", rx_data, rx_valid);
    end
    checks++; if (fe_cnt - f0 !== 1 || ov_cnt != o0) begin
      errors++; $display("FAIL ferr_counts: frame_err=%0d overrun=%0d expected 1 0", fe_cnt - f0, ov_cnt - o0);
    end
    pop_one();
  endtask

  task automatic test_overrun();
    int s, o0;
    o0 = ov_cnt;
    send_rx(8'h11, 1'b1, s);
    send_rx(8'h22, 1'b1, s);
    repeat (4) @(negedge clk);
`ifdef UART_RX_FIFO_EN
    checks++; if (ov_cnt != o0) begin errors++; $display("FAIL fifo_no_overrun: got %0d expected 0", ov_cnt - o0); end
    checks++; if (rx_data !== 8'h11 || rx_valid !== 1'b1) begin
      errors++; $display("FAIL fifo_head1: rx_data=%h rx_valid=%b expected 11 1", rx_data, rx_valid);
    end
    pop_one();
    checks++; if (rx_data !== 8'h22 || rx_valid !== 1'b1) begin
      errors++; $display("FAIL fifo_head2: rx_data=%h rx_valid=%b expected 22 1", rx_data, rx_valid);
    end
    pop_one();
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL fifo_empty: rx_valid=%b expected 0", rx_valid); end
`else
    checks++; if (ov_cnt - o0 !== 1) begin errors++; $display("FAIL overrun_pulse: got %0d expected 1", ov_cnt - o0); end
    checks++; if (rx_data !== 8'h11 || rx_valid !== 1'b1) begin
      errors++; $display("FAIL overrun_keep_old: rx_data=%h rx_valid=%b expected 11 1", rx_data, rx_valid);
    end
    pop_one();
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL overrun_pop: rx_valid=%b expected 0", rx_valid); end
`endif
  endtask

  task automatic test_glitch();
    int r0, f0, o0;
    r0 = rise_cnt; f0 = fe_cnt; o0 = ov_cnt;
    @(negedge clk);
    ser_rx = 1'b0;
    repeat (8) @(negedge clk);
    ser_rx = 1'b1;
    repeat (200) @(negedge clk);
    checks++; if (rise_cnt != r0 || rx_valid !== 1'b0) begin
      errors++; $display("FAIL glitch_valid: rises=%0d rx_valid=%b expected 0 0", rise_cnt - r0, rx_valid);
    end
    checks++; if (fe_cnt != f0 || ov_cnt != o0) begin
      errors++; $display("FAIL glitch_errors: frame_err=%0d overrun=%0d expected 0 0", fe_cnt - f0, ov_cnt - o0);
    end
  endtask

  task automatic test_reset_mid_tx();
    int d0;
    @(negedge clk);
    tx_start = 1'b1;
    tx_data  = 8'h00;
    @(posedge clk);
    #1;
    tx_start = 1'b0;
    repeat (50) @(posedge clk);
    @(negedge clk);
    checks++; if (ser_tx !== 1'b0 || tx_busy !== 1'b1) begin
      errors++; $display("FAIL midtx_before: ser_tx=%b tx_busy=%b expected 0 1", ser_tx, tx_busy);
    end
    d0 = done_cnt;
    rst_n = 1'b0;
    #1;
    checks++; if (ser_tx !== 1'b1 || tx_busy !== 1'b0) begin
      errors++; $display("FAIL midtx_reset: ser_tx=%b tx_busy=%b expected 1 0", ser_tx, tx_busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (200) @(negedge clk);
    checks++; if (done_cnt != d0) begin errors++; $display("FAIL midtx_no_done: got %0d expected 0", done_cnt - d0); end
    tx_frame(8'hFF);
  endtask

  initial begin
    test_reset();
    test_tx();
    test_back_to_back();
    test_rx_basic();
    test_frame_err();
    test_overrun();
    test_glitch();
    test_reset_mid_tx();
    repeat (4) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
